game_timer: RTL and testbench
=============================

// Module: game_timer
//
// PURPOSE
// Parametrised single-clock timer/counter for the BlackJack FSM; successor to the
// two-clock counter. An internal prescaler derives a tick of TICK_HZ from the 50 MHz
// clock, and a WIDTH-bit counter advances on each tick in one of three modes: free-run,
// one-shot timeout (e.g. the FSM's two-second wait) or periodic. The FSM starts, stops
// and clears it and sees a one-cycle o_Done pulse at terminal count.
//
// PARAMETERS
// WIDTH    12          counter width in bits (>=2)
// CLK_HZ   50_000_000  frequency of clk_50M
// TICK_HZ  2_000       tick rate; DIV = CLK_HZ/TICK_HZ (integer, >=1)
//
// PORTS
// clk_50M   in   1      system clock, all logic on rising edge
// i_Reset   in   1      synchronous reset, active-low
// i_Start   in   1      start/restart: latch i_Mode and i_Limit, clear count, run
// i_Stop    in   1      halt counting, hold o_Count
// i_Zero    in   1      clear count and prescaler, run state unchanged
// i_Mode    in   2      0=FREE, 1=ONESHOT, 2=PERIODIC, 3=treated as ONESHOT
// i_Limit   in   WIDTH  terminal count for ONESHOT/PERIODIC (0 treated as 1)
// o_Count   out  WIDTH  current count (ticks since start)
// o_Busy    out  1      high while in RUN
// o_Tick    out  1      one-cycle pulse per prescaler tick while RUN
// o_Done    out  1      one-cycle pulse at terminal count / wrap
//
// BEHAVIOUR
// - Reset (i_Reset==0 at edge): state IDLE, count 0, prescaler 0, latched mode/limit 0,
//   all outputs 0. Reset overrides every other input.
// - States: IDLE, RUN. Priority among inputs when out of reset:
//   i_Start > i_Stop > i_Zero > tick.
// - i_Start (any state): mode/limit latched, count<=0, prescaler<=0, state<=RUN,
//   o_Done<=0. Restart mid-run discards progress; no o_Done for the aborted run.
// - i_Stop in RUN: state<=IDLE, count held, prescaler<=0, no o_Done. Ignored in IDLE.
// - i_Zero: count<=0, prescaler<=0; state kept. In IDLE with count held, clears it.
// - Prescaler: counts 0..DIV-1 in RUN only; tick when it equals DIV-1, then wraps to 0.
//   First tick after start occurs on the DIV-th rising edge after the start edge.
//   DIV==1: tick every cycle in RUN.
// - On a tick in RUN (o_Tick high the cycle after, registered):
//   FREE:     count<=count+1 mod 2^WIDTH; o_Done pulses on 2^WIDTH-1 -> 0 wrap; stays RUN.
//   ONESHOT:  count<=count+1; if count+1==limit: o_Done pulse, state<=IDLE, count
//             held at limit.
//   PERIODIC: if count+1==limit: count<=0, o_Done pulse, stays RUN; else count+1.
// - Latency: o_Count, o_Done, o_Tick, o_Busy all registered and update on the same edge
//   as the tick that causes them; o_Done is high exactly one cycle.
// - Latched limit of 0 behaves as 1 (Done on first tick). Changes on i_Mode/i_Limit
//   while RUN have no effect until the next i_Start.
// - Count never exceeds latched limit in ONESHOT/PERIODIC; unused mode 3 == ONESHOT.
//
// TESTING  (CLK_HZ=8, TICK_HZ=2 -> DIV=4, WIDTH=4 unless stated)
// 1 Reset: hold i_Reset=0 mid-run 1 cycle -> next cycle o_Count=0, o_Busy=0,
//   o_Done=0, o_Tick=0; i_Reset must have no effect between edges.
// 2 ONESHOT limit=3: start at edge 0 -> o_Tick at edges 4,8,12; o_Count 1,2,3;
//   o_Done high only after edge 12; o_Busy falls same edge; count holds 3.
// 3 PERIODIC limit=2: run 20 cycles -> o_Count 1,0,1,0,1; o_Done pulses after
//   edges 8 and 16; o_Busy stays 1.
// 4 FREE, WIDTH=4: run 64 cycles -> count wraps 15->0 at edge 64, one o_Done pulse.
// 5 Stop/Zero/Restart: i_Stop at count 2 -> holds 2, o_Busy=0, no o_Done; i_Zero ->
//   count 0; i_Start+i_Stop same cycle -> RUN, count 0 (start wins).
// 6 limit=0 ONESHOT -> o_Done after first tick (edge 4), count 1;
//   DIV=1 build -> tick every cycle.

Source files
------------

// File: rtl/game_timer.sv
// Single-clock prescaled timer for the BlackJack FSM: free-run, one-shot and periodic
// modes, start/stop/zero control and a one-cycle done pulse at terminal count.
module game_timer #(
    parameter int          WIDTH   = 12,
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 2_000
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic             i_Stop,
    input  logic             i_Zero,
    input  logic [1:0]       i_Mode,
    input  logic [WIDTH-1:0] i_Limit,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_Busy,
    output logic             o_Tick,
    output logic             o_Done
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    DIV_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE = PW'(1);
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [1:0]       MODE_FREE     = 2'd0;
    localparam logic [1:0]       MODE_PERIODIC = 2'd2;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] count_r, count_s;
    logic [PW-1:0]    presc_r, presc_s;
    logic [1:0]       mode_r, mode_s;
    logic [WIDTH-1:0] limit_r, limit_s;
    logic             tick_r, tick_s;
    logic             done_r, done_s;
    logic             busy_r;
    logic [WIDTH-1:0] count_inc_s;
    logic [WIDTH-1:0] eff_limit_s;

    // Next-state, datapath and output decode; priority start > stop > zero > tick.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        presc_s     = presc_r;
        mode_s      = mode_r;
        limit_s     = limit_r;
        tick_s      = 1'b0;
        done_s      = 1'b0;
        count_inc_s = count_r + CNT_ONE;
        // A latched limit of zero behaves as one so the run still terminates.
        eff_limit_s = (limit_r == CNT_ZERO) ? CNT_ONE : limit_r;

        if (i_Start) begin
            mode_s  = i_Mode;
            limit_s = i_Limit;
            count_s = CNT_ZERO;
            presc_s = {PW{1'b0}};
            state_s = RUN;
        end else if (i_Stop && (state_r == RUN)) begin
            state_s = IDLE;
            presc_s = {PW{1'b0}};
        end else if (i_Zero) begin
            count_s = CNT_ZERO;
            presc_s = {PW{1'b0}};
        end else if (state_r == RUN) begin
            if (presc_r != DIV_LAST) begin
                presc_s = presc_r + PRESC_ONE;
            end else begin
                presc_s = {PW{1'b0}};
                tick_s  = 1'b1;
                case (mode_r)
                    MODE_FREE: begin
                        count_s = count_inc_s;
                        done_s  = (count_r == CNT_MAX);
                    end
                    MODE_PERIODIC: begin
                        if (count_inc_s == eff_limit_s) begin
                            count_s = CNT_ZERO;
                            done_s  = 1'b1;
                        end else begin
                            count_s = count_inc_s;
                        end
                    end
                    default: begin
                        count_s = count_inc_s;
                        if (count_inc_s == eff_limit_s) begin
                            done_s  = 1'b1;
                            state_s = IDLE;
                        end else begin
                            state_s = RUN;
                        end
                    end
                endcase
            end
        end else begin
            presc_s = {PW{1'b0}};
        end
    end

    // State, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk_50M) begin
        if (!i_Reset) begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            presc_r <= {PW{1'b0}};
            mode_r  <= 2'd0;
            limit_r <= CNT_ZERO;
            tick_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            presc_r <= presc_s;
            mode_r  <= mode_s;
            limit_r <= limit_s;
            tick_r  <= tick_s;
            done_r  <= done_s;
            busy_r  <= (state_s == RUN);
        end
    end

    assign o_Count = count_r;
    assign o_Busy  = busy_r;
    assign o_Tick  = tick_r;
    assign o_Done  = done_r;

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer: DIV=4/WIDTH=4 main instance plus a
// DIV=1 instance sharing the same stimulus.
module tb_game_timer;

    logic       clk = 1'b0;
    logic       i_Reset, i_Start, i_Stop, i_Zero;
    logic [1:0] i_Mode;
    logic [3:0] i_Limit;
    logic [3:0] o_Count, o1_Count;
    logic       o_Busy, o_Tick, o_Done;
    logic       o1_Busy, o1_Tick, o1_Done;

    int n_checks = 0;
    int n_fail   = 0;

    game_timer #(.WIDTH(4), .CLK_HZ(8), .TICK_HZ(2)) dut (
        .clk_50M(clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Stop(i_Stop),
        .i_Zero(i_Zero), .i_Mode(i_Mode), .i_Limit(i_Limit),
        .o_Count(o_Count), .o_Busy(o_Busy), .o_Tick(o_Tick), .o_Done(o_Done)
    );

    game_timer #(.WIDTH(4), .CLK_HZ(8), .TICK_HZ(8)) dut1 (
        .clk_50M(clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Stop(i_Stop),
        .i_Zero(i_Zero), .i_Mode(i_Mode), .i_Limit(i_Limit),
        .o_Count(o1_Count), .o_Busy(o1_Busy), .o_Tick(o1_Tick), .o_Done(o1_Done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input bit busy,
                           input bit tick, input bit done);
        chk({tag, ".count"}, 32'(o_Count), 32'(cnt));
        chk({tag, ".busy"},  32'(o_Busy),  32'(busy));
        chk({tag, ".tick"},  32'(o_Tick),  32'(tick));
        chk({tag, ".done"},  32'(o_Done),  32'(done));
    endtask

    task automatic start(input logic [1:0] mode, input logic [3:0] lim);
        i_Mode  = mode;
        i_Limit = lim;
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
    endtask

    initial begin
        i_Reset = 1'b0; i_Start = 1'b0; i_Stop = 1'b0; i_Zero = 1'b0;
        i_Mode = 2'd0; i_Limit = 4'd0;
        step(); step();
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
        i_Reset = 1'b1;
        step();
        chk_all("idle", 0, 1'b0, 1'b0, 1'b0);

        // ONESHOT limit 3, with mode/limit inputs changed after the start edge
        start(2'd1, 4'd3);
        chk_all("os.e0", 0, 1'b1, 1'b0, 1'b0);
        i_Mode = 2'd2; i_Limit = 4'd7;
        for (int e = 1; e <= 14; e++) begin
            step();
            chk_all($sformatf("os.e%0d", e), (e >= 12) ? 3 : e / 4, e < 12,
                    (e % 4 == 0) && (e <= 12), e == 12);
        end

        // Reset mid-run; a glitch between edges must be invisible
        start(2'd0, 4'd0);
        for (int e = 1; e <= 6; e++) step();
        chk_all("rst.pre", 1, 1'b1, 1'b0, 1'b0);
        i_Reset = 1'b0; #2; i_Reset = 1'b1;
        step();
        chk_all("rst.glitch", 1, 1'b1, 1'b0, 1'b0);
        i_Reset = 1'b0;
        step();
        i_Reset = 1'b1;
        chk_all("rst.mid", 0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("rst.after", 0, 1'b0, 1'b0, 1'b0);

        // PERIODIC limit 2
        start(2'd2, 4'd2);
        for (int e = 1; e <= 20; e++) begin
            step();
            chk_all($sformatf("per.e%0d", e), (e / 4) % 2, 1'b1, e % 4 == 0, e % 8 == 0);
        end

        // FREE restart mid-run: no done for the aborted periodic run
        start(2'd0, 4'd0);
        chk_all("free.e0", 0, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 66; e++) begin
            step();
            chk_all($sformatf("free.e%0d", e), (e / 4) % 16, 1'b1, e % 4 == 0, e == 64);
        end

        // Stop / Zero / Start-beats-Stop
        start(2'd1, 4'd5);
        for (int e = 1; e <= 8; e++) step();
        chk_all("ss.cnt2", 2, 1'b1, 1'b1, 1'b0);
        i_Stop = 1'b1;
        step();
        i_Stop = 1'b0;
        chk_all("ss.stop", 2, 1'b0, 1'b0, 1'b0);
        for (int e = 1; e <= 5; e++) step();
        chk_all("ss.hold", 2, 1'b0, 1'b0, 1'b0);
        i_Zero = 1'b1;
        step();
        i_Zero = 1'b0;
        chk_all("ss.zero_idle", 0, 1'b0, 1'b0, 1'b0);
        i_Start = 1'b1; i_Stop = 1'b1;
        step();
        i_Start = 1'b0; i_Stop = 1'b0;
        chk_all("ss.start_wins", 0, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 4; e++) step();
        chk_all("ss.tick1", 1, 1'b1, 1'b1, 1'b0);
        step();
        i_Zero = 1'b1;
        step();
        i_Zero = 1'b0;
        chk_all("ss.zero_run", 0, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 3; e++) step();
        chk_all("ss.presc_clr", 0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("ss.tick_after_zero", 1, 1'b1, 1'b1, 1'b0);

        // DIV=1 instance: tick every cycle in FREE
        start(2'd0, 4'd0);
        for (int e = 1; e <= 5; e++) begin
            step();
            chk($sformatf("div1.cnt.e%0d", e), 32'(o1_Count), 32'(e));
            chk($sformatf("div1.tick.e%0d", e), 32'(o1_Tick), 32'd1);
        end

        // ONESHOT with limit 0 behaves as limit 1
        start(2'd1, 4'd0);
        chk("div1.lim0.e0", 32'(o1_Done), 32'd0);
        for (int e = 1; e <= 5; e++) begin
            step();
            chk_all($sformatf("lim0.e%0d", e), (e >= 4) ? 1 : 0, e < 4, e == 4, e == 4);
            if (e == 1) begin
                chk("div1.lim0.done", 32'(o1_Done), 32'd1);
                chk("div1.lim0.busy", 32'(o1_Busy), 32'd0);
            end
        end

        // Mode 3 behaves as ONESHOT
        start(2'd3, 4'd1);
        for (int e = 1; e <= 5; e++) begin
            step();
            chk_all($sformatf("m3.e%0d", e), (e >= 4) ? 1 : 0, e < 4, e == 4, e == 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
